ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: word-aligned PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch byte address; bits [1:0] always 2'b00.
REQ-006 imem_ack  input  1  memory response valid; imem_rdata sampled this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 stall  input  1  downstream decode/execute not ready to consume the held instruction.
REQ-009 redirect  input  1  taken branch (Branch AND Zero from datapath); replaces PC.
REQ-010 redirect_pc  input  32  branch target; bits [1:0] ignored and treated as 2'b00.
REQ-011 instr_valid  output  1  held instruction and fields are valid for decode.
REQ-012 instr_pc  output  32  address of the held instruction.
REQ-013 pc_plus4  output  32  instr_pc + 4, for branch target computation downstream.
REQ-014 OP  output  6  IR[31:26], drives the decoder opcode input.
REQ-015 Funct  output  6  IR[5:0], drives the decoder function input.
REQ-016 Rs, Rt, Rd  output  5 each  IR[25:21], IR[20:16], IR[15:11].
REQ-017 Imm  output  16  IR[15:0], unextended.

Function
REQ-018 Two-state FSM: FETCH and HOLD; the FSM enters FETCH on reset.
REQ-019 FETCH: imem_req=1, imem_addr=PC, instr_valid=0; on imem_ack: IR<=imem_rdata, instr_pc<=PC, PC<=PC+4, next state HOLD.
REQ-020 FETCH without imem_ack: remain in FETCH with imem_req and imem_addr held stable.
REQ-021 HOLD: imem_req=0, instr_valid=1; stall=1 keeps IR, instr_pc and all field outputs unchanged; stall=0 consumes the instruction, next state FETCH.
REQ-022 Latency: instr_valid rises exactly one cycle after the imem_ack cycle; minimum issue interval is 2 cycles per instruction.
REQ-023 Redirect priority is redirect > imem_ack > stall: redirect=1 in any state sets PC<={redirect_pc[31:2],2'b00} and next state FETCH; instr_valid is 0 in the following cycle.
REQ-024 redirect and imem_ack in the same cycle: imem_rdata is discarded, IR is unchanged, and the next request uses the redirect target.
REQ-025 redirect in HOLD with stall=1: the held instruction is squashed regardless of stall.
REQ-026 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-027 imem_req is never asserted while reset=1.

Reset
REQ-028 Asynchronous assertion gives: state=FETCH, PC=RESET_PC, instr_pc=RESET_PC, IR=0 (OP, Funct, Rs, Rt, Rd and Imm all 0), instr_valid=0.
REQ-029 The first imem_req=1 occurs in the first cycle after reset deasserts, with imem_addr=RESET_PC.
REQ-030 Reset mid-fetch abandons the outstanding request; a late imem_ack while reset=1 or in the first post-reset cycle before req is ignored.

Configuration
REQ-031 Macro IFETCH_CNT_EN defined: add output fetch_count (32 bits), reset to 0, incremented on each instruction consumed in HOLD (stall=0, redirect=0), wrapping modulo 2^32.
REQ-032 Macro IFETCH_CNT_EN undefined: no fetch_count port and no counter logic; all other behaviour is identical.

Structure
REQ-033 Shared package mips_pkg holds: opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100; the fetch state enum (FETCH, HOLD); the instruction field position constants.
REQ-034 One sub-module, pc_reg: holds PC with async reset to RESET_PC and load/increment controls; the FSM, IR and field split stay in ifetch_unit.

Verification
REQ-035 Reset released, memory acks every request in the same cycle, stall=0: imem_addr sequence 0x0, 0x4, 0x8; instr_valid high on alternate cycles; instr_pc follows 0x0, 0x4, 0x8.
REQ-036 Memory delays ack by 3 cycles with rdata=32'h8C22_0004 (lw): imem_addr is stable for 4 cycles; then OP=6'b100011, Rs=1, Rt=2, Imm=16'h0004.
REQ-037 HOLD with stall=1 for 5 cycles on R-type 32'h0022_1820: outputs are constant; Funct=6'b100000 and Rd=3 throughout; no imem_req during the stall.
REQ-038 redirect=1 with redirect_pc=32'h0000_0103 in the same cycle as imem_ack: IR is unchanged, instr_valid=0, next imem_addr=32'h0000_0100.
REQ-039 RESET_PC=32'hFFFF_FFFC, one fetch: pc_plus4=32'h0000_0000 and the next imem_addr=32'h0000_0000.
REQ-040 Reset asserted mid-FETCH and mid-HOLD: all outputs take the REQ-028 values in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the instruction fetch logic.
//   - MIPS opcode constants used by the decoder side
//   - fetch FSM state encoding
//   - bit positions of the instruction fields inside the 32-bit word
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter register for the fetch unit.
// The PC is kept as a 30-bit word address so the byte address is always
// word aligned and the +4 step wraps modulo 2^32 naturally.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (PC <= RESET_PC)
//   i_load       load i_load_pc (takes priority over i_inc)
//   i_load_pc    target word address (byte address bits [31:2])
//   i_inc        advance PC by one word
//   o_pc         current byte address, bits [1:0] = 2'b00
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [29:0] i_load_pc,
  input  logic        i_inc,
  output logic [31:0] o_pc
);

  logic [29:0] r_pc_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_word <= RESET_PC[31:2];
    end else if (i_load) begin
      r_pc_word <= i_load_pc;
    end else if (i_inc) begin
      r_pc_word <= r_pc_word + 30'd1;
    end
  end

  assign o_pc = {r_pc_word, 2'b00};

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetch unit.
// Fetches one word, holds it for decode until consumed, then fetches the
// next. A taken branch (redirect) overrides everything and refetches.
//
// state | meaning
// FETCH | request outstanding at PC, waiting for imem_ack
// HOLD  | instruction held in IR, valid for decode until stall drops
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   imem_req/imem_addr       fetch request and word-aligned byte address
//   imem_ack/imem_rdata      memory response and instruction word
//   stall                    downstream not ready to consume held instr
//   redirect/redirect_pc     taken-branch PC replacement
//   instr_valid/instr_pc     held instruction valid and its address
//   pc_plus4                 instr_pc + 4
//   OP/Funct/Rs/Rt/Rd/Imm    fields of the held instruction
//   fetch_count              consumed-instruction counter (IFETCH_CNT_EN)
//
// Build option: define IFETCH_CNT_EN to add the fetch_count output.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic [5:0]  OP,
  output logic [5:0]  Funct,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [15:0] Imm
`ifdef IFETCH_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_ir;
  logic [31:0]  r_instr_pc;
  logic [31:0]  w_pc;
  logic         w_capture;
  logic         w_consume;
  logic         w_unused_rpc;

  // Low target bits are forced to zero; they are intentionally dropped.
  assign w_unused_rpc = ^redirect_pc[1:0];

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .i_load    (redirect),
    .i_load_pc (redirect_pc[31:2]),
    .i_inc     (w_capture),
    .o_pc      (w_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Redirect wins over a same-cycle ack (response dropped) and over stall.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_consume   = 1'b0;
    if (redirect) begin
      w_state_nxt = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            w_consume   = 1'b1;
            w_state_nxt = FETCH;
          end
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir       <= 32'h0;
      r_instr_pc <= RESET_PC;
    end else if (w_capture) begin
      r_ir       <= imem_rdata;
      r_instr_pc <= w_pc;
    end
  end

  // The request is gated by reset so nothing is issued while it is held.
  assign imem_req    = (r_state == FETCH) && !reset;
  assign imem_addr   = w_pc;
  assign instr_valid = (r_state == HOLD);
  assign instr_pc    = r_instr_pc;
  assign pc_plus4    = r_instr_pc + 32'd4;

  assign OP    = r_ir[OP_HI:OP_LO];
  assign Funct = r_ir[FUNCT_HI:FUNCT_LO];
  assign Rs    = r_ir[RS_HI:RS_LO];
  assign Rt    = r_ir[RT_HI:RT_LO];
  assign Rd    = r_ir[RD_HI:RD_LO];
  assign Imm   = r_ir[IMM_HI:IMM_LO];

`ifdef IFETCH_CNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count <= 32'h0;
    end else if (w_consume) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [5:0]  OP;
  logic [5:0]  Funct;
  logic [4:0]  Rs, Rt, Rd;
  logic [15:0] Imm;

  logic        b_req;
  logic [31:0] b_addr;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic        b_stall;
  logic        b_valid;
  logic [31:0] b_ipc;
  logic [31:0] b_pc4;
  logic [5:0]  b_op, b_funct;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [15:0] b_imm;
`ifdef IFETCH_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] b_fetch_count;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .OP(OP), .Funct(Funct), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm)
`ifdef IFETCH_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(b_ack), .imem_rdata(b_rdata),
    .stall(b_stall), .redirect(1'b0), .redirect_pc(32'h0),
    .instr_valid(b_valid), .instr_pc(b_ipc), .pc_plus4(b_pc4),
    .OP(b_op), .Funct(b_funct), .Rs(b_rs), .Rt(b_rt), .Rd(b_rd), .Imm(b_imm)
`ifdef IFETCH_CNT_EN
    , .fetch_count(b_fetch_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ipc;
    logic        chk_ir;
    logic [31:0] exp_ir;
  } vec_t;
  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_fields(input string pfx, input logic [31:0] ir);
    chk({pfx, "_op"},    32'(OP),    32'(ir[31:26]));
    chk({pfx, "_rs"},    32'(Rs),    32'(ir[25:21]));
    chk({pfx, "_rt"},    32'(Rt),    32'(ir[20:16]));
    chk({pfx, "_rd"},    32'(Rd),    32'(ir[15:11]));
    chk({pfx, "_funct"}, 32'(Funct), 32'(ir[5:0]));
    chk({pfx, "_imm"},   32'(Imm),   32'(ir[15:0]));
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_req"},   32'(imem_req),    32'h0);
    chk({pfx, "_addr"},  imem_addr,        32'h0);
    chk({pfx, "_valid"}, 32'(instr_valid), 32'h0);
    chk({pfx, "_ipc"},   instr_pc,         32'h0);
    chk({pfx, "_pc4"},   pc_plus4,         32'h4);
    chk_fields(pfx, 32'h0);
    chk({pfx, "_b_ipc"}, b_ipc,            32'hFFFF_FFFC);
    chk({pfx, "_b_req"}, 32'(b_req),       32'h0);
  endtask

  function automatic vec_t mk(input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] eipc, input logic ack, input logic [31:0] rd,
                              input logic st, input logic rdr, input logic [31:0] rpc,
                              input logic ci, input logic [31:0] eir);
    vec_t v;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_ipc = eipc;
    v.ack = ack; v.rdata = rd; v.stall = st; v.redir = rdr; v.rpc = rpc;
    v.chk_ir = ci; v.exp_ir = eir;
    return v;
  endfunction

  // Scoreboard consumer: pops on each rising instr_valid, then keeps
  // checking the fields stay on that word for as long as valid is high.
  logic prev_valid = 1'b0;
  sb_t  cur_exp;
  logic have_exp = 1'b0;
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_pop: got empty queue expected an entry");
        have_exp <= 1'b0;
      end else begin
        cur_exp = sb_q.pop_front();
        have_exp <= 1'b1;
        chk("sb_ipc", instr_pc, cur_exp.pc);
        chk_fields("sb", cur_exp.ir);
      end
    end else if (instr_valid && have_exp) begin
      chk("sb_hold_ipc", instr_pc, cur_exp.pc);
      chk_fields("sb_hold", cur_exp.ir);
    end
    prev_valid <= instr_valid;
  end

  initial begin
    vec_t v;
    //            req addr          vld ipc           ack rdata         st rd rpc           ci ir
    vecs[0]  = mk(1, 32'h0000_0000, 0, 32'h0000_0000, 1, 32'h0000_0020, 0, 0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(0, 32'h0000_0004, 1, 32'h0000_0000, 0, 32'h0,         0, 0, 32'h0,        1, 32'h0000_0020);
    vecs[2]  = mk(1, 32'h0000_0004, 0, 32'h0000_0000, 1, 32'h1000_0003, 0, 0, 32'h0,        0, 32'h0);
    vecs[3]  = mk(0, 32'h0000_0008, 1, 32'h0000_0004, 0, 32'h0,         0, 0, 32'h0,        1, 32'h1000_0003);
    vecs[4]  = mk(1, 32'h0000_0008, 0, 32'h0000_0004, 1, 32'hAC43_0008, 0, 0, 32'h0,        0, 32'h0);
    vecs[5]  = mk(0, 32'h0000_000C, 1, 32'h0000_0008, 0, 32'h0,         0, 0, 32'h0,        1, 32'hAC43_0008);
    vecs[6]  = mk(1, 32'h0000_000C, 0, 32'h0000_0008, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0);
    vecs[7]  = mk(1, 32'h0000_000C, 0, 32'h0000_0008, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0);
    vecs[8]  = mk(1, 32'h0000_000C, 0, 32'h0000_0008, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0);
    vecs[9]  = mk(1, 32'h0000_000C, 0, 32'h0000_0008, 1, 32'h8C22_0004, 0, 0, 32'h0,        0, 32'h0);
    vecs[10] = mk(0, 32'h0000_0010, 1, 32'h0000_000C, 0, 32'h0,         0, 0, 32'h0,        1, 32'h8C22_0004);
    vecs[11] = mk(1, 32'h0000_0010, 0, 32'h0000_000C, 1, 32'h0022_1820, 0, 0, 32'h0,        0, 32'h0);
    vecs[12] = mk(0, 32'h0000_0014, 1, 32'h0000_0010, 0, 32'h0,         1, 0, 32'h0,        1, 32'h0022_1820);
    vecs[13] = mk(0, 32'h0000_0014, 1, 32'h0000_0010, 0, 32'h0,         1, 0, 32'h0,        1, 32'h0022_1820);
    vecs[14] = mk(0, 32'h0000_0014, 1, 32'h0000_0010, 0, 32'h0,         1, 0, 32'h0,        1, 32'h0022_1820);
    vecs[15] = mk(0, 32'h0000_0014, 1, 32'h0000_0010, 0, 32'h0,         1, 0, 32'h0,        1, 32'h0022_1820);
    vecs[16] = mk(0, 32'h0000_0014, 1, 32'h0000_0010, 0, 32'h0,         1, 0, 32'h0,        1, 32'h0022_1820);
    vecs[17] = mk(0, 32'h0000_0014, 1, 32'h0000_0010, 0, 32'h0,         0, 0, 32'h0,        1, 32'h0022_1820);
    vecs[18] = mk(1, 32'h0000_0014, 0, 32'h0000_0010, 1, 32'hDEAD_BEEF, 0, 1, 32'h0000_0103, 0, 32'h0);
    vecs[19] = mk(1, 32'h0000_0100, 0, 32'h0000_0010, 1, 32'h1000_0001, 0, 0, 32'h0,        1, 32'h0022_1820);
    vecs[20] = mk(0, 32'h0000_0104, 1, 32'h0000_0100, 0, 32'h0,         1, 1, 32'h0000_0200, 1, 32'h1000_0001);
    vecs[21] = mk(1, 32'h0000_0200, 0, 32'h0000_0100, 1, 32'hAC43_0008, 0, 0, 32'h0,        0, 32'h0);
    vecs[22] = mk(0, 32'h0000_0204, 1, 32'h0000_0200, 0, 32'h0,         0, 0, 32'h0,        1, 32'hAC43_0008);
    vecs[23] = mk(1, 32'h0000_0204, 0, 32'h0000_0200, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0);

    reset = 1'b1;
    imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    b_ack = 1'b0; b_rdata = 32'h0; b_stall = 1'b0;

    #3;
    chk_reset("por");
`ifdef IFETCH_CNT_EN
    chk("por_cnt", fetch_count, 32'h0);
`endif
    // A response arriving while reset is held must be ignored.
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_reset("por_late_ack");
    imem_ack = 1'b0;
    reset = 1'b0;
    #1;

    for (int i = 0; i < 24; i++) begin
      v = vecs[i];
      chk($sformatf("r%0d_req", i),   32'(imem_req),    32'(v.exp_req));
      chk($sformatf("r%0d_addr", i),  imem_addr,        v.exp_addr);
      chk($sformatf("r%0d_valid", i), 32'(instr_valid), 32'(v.exp_valid));
      chk($sformatf("r%0d_ipc", i),   instr_pc,         v.exp_ipc);
      chk($sformatf("r%0d_pc4", i),   pc_plus4,         v.exp_ipc + 32'd4);
      if (v.chk_ir) chk_fields($sformatf("r%0d", i), v.exp_ir);
      imem_ack = v.ack; imem_rdata = v.rdata; stall = v.stall;
      redirect = v.redir; redirect_pc = v.rpc;
      if (v.ack && v.exp_req && !v.redir) sb_q.push_back({v.exp_addr, v.rdata});
      @(negedge clk);
    end
`ifdef IFETCH_CNT_EN
    chk("cnt_after_table", fetch_count, 32'd6);
`endif

    // Reset in the middle of a fetch, with a late ack across the edge.
    #2;
    reset = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk_reset("rst_fetch");
`ifdef IFETCH_CNT_EN
    chk("rst_fetch_cnt", fetch_count, 32'h0);
`endif
    @(negedge clk);
    chk_reset("rst_fetch_edge");
    imem_ack = 1'b0;
    reset = 1'b0;
    #1;
    chk("post_rst_req",   32'(imem_req),    32'h1);
    chk("post_rst_addr",  imem_addr,        32'h0);
    chk("post_rst_valid", 32'(instr_valid), 32'h0);

    // Reset while an instruction is held under stall.
    imem_ack = 1'b1; imem_rdata = 32'h0022_1820; stall = 1'b1;
    sb_q.push_back({32'h0, 32'h0022_1820});
    @(negedge clk);
    chk("hold_valid", 32'(instr_valid), 32'h1);
    chk("hold_req",   32'(imem_req),    32'h0);
    imem_ack = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_reset("rst_hold");
    @(negedge clk);
    stall = 1'b0;
    reset = 1'b0;
    #1;
    chk("post_rst2_req", 32'(imem_req), 32'h1);

    // Wrap: second instance starts at the last word of the address space.
    chk("wrap_req",  32'(b_req), 32'h1);
    chk("wrap_addr", b_addr,     32'hFFFF_FFFC);
    b_ack = 1'b1; b_rdata = 32'h8C22_0004;
    @(negedge clk);
    b_ack = 1'b0;
    chk("wrap_valid", 32'(b_valid), 32'h1);
    chk("wrap_ipc",   b_ipc,        32'hFFFF_FFFC);
    chk("wrap_pc4",   b_pc4,        32'h0000_0000);
    chk("wrap_op",    32'(b_op),    32'(6'b100011));
    chk("wrap_imm",   32'(b_imm),   32'h0004);
    @(negedge clk);
    chk("wrap_next_req",  32'(b_req), 32'h1);
    chk("wrap_next_addr", b_addr,     32'h0000_0000);
`ifdef IFETCH_CNT_EN
    chk("wrap_cnt", b_fetch_count, 32'd1);
`endif

    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
